reg_write_tracer: RTL and testbench

Synthesisable register-write tracer for the processor's writeback path. Keeps a shadow copy of the architectural register file from one or more writeback channels. Timestamps every accepted write into a log FIFO that a bench or debug port drains over a valid/ready handshake. Replaces the ad-hoc per-clock register dump with a parametrised, multi-port, change-filtered trace.

---
 rtl/reg_write_tracer.sv | 134 +++++++++++++
 tb/tb_reg_write_tracer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_tracer.sv
// Register-write tracer: keeps a shadow copy of the register file from several
// writeback ports and logs timestamped writes into a FIFO drained by valid/ready.
module reg_write_tracer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 2,
  parameter int LOG_DEPTH = 16,
  parameter int CYC_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
  input  logic                          changes_only,
  input  logic                          clr_log,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          log_valid,
  input  logic                          log_ready,
  output logic [CYC_W-1:0]              log_cycle,
  output logic [1:0]                    log_port,
  output logic [ADDR_W-1:0]             log_addr,
  output logic [DATA_W-1:0]             log_data,
  output logic [$clog2(LOG_DEPTH):0]    log_count,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic [DATA_W-1:0] shadow [NREG];
  logic [CYC_W-1:0]  cyc;

  logic [CYC_W-1:0]  q_cyc  [LOG_DEPTH];
  logic [1:0]        q_port [LOG_DEPTH];
  logic [ADDR_W-1:0] q_addr [LOG_DEPTH];
  logic [DATA_W-1:0] q_data [LOG_DEPTH];

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 pop;
  logic [CNT_W-1:0]     free;
  logic [CNT_W-1:0]     n_acc;
  logic [2:0]           n_drop;
  logic [NUM_PORTS-1:0] loggable;
  logic [NUM_PORTS-1:0] accept;
  logic [PTR_W-1:0]     slot [NUM_PORTS];
  logic [16:0]          drop_sum;

  // Ports are granted FIFO slots in ascending order; the change filter compares
  // against the shadow as it stood at the start of the cycle.
  always_comb begin
    pop      = (count != '0) && log_ready;
    free     = CNT_W'(LOG_DEPTH) - count + CNT_W'(pop);
    n_acc    = '0;
    n_drop   = '0;
    loggable = '0;
    accept   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot[p] = wr_ptr + PTR_W'(n_acc);
      loggable[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0) &&
                    (!changes_only ||
                     (wr_data[p*DATA_W +: DATA_W] != shadow[wr_addr[p*ADDR_W +: ADDR_W]]));
      if (loggable[p]) begin
        if (n_acc < free) begin
          accept[p] = 1'b1;
          n_acc     = n_acc + CNT_W'(1);
        end else begin
          n_drop = n_drop + 3'd1;
        end
      end
    end
    drop_sum = {1'b0, drop_count} + 17'(n_drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      rd_data    <= '0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      cyc     <= cyc + CYC_W'(1);
      rd_data <= shadow[rd_addr];
      // Later ports override earlier ones on the same address.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0))
          shadow[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      end
      if (clr_log) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count  <= count + n_acc - CNT_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(n_acc);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        if (n_drop != '0) begin
          overflow   <= 1'b1;
          drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!reset && !clr_log) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          q_cyc[slot[p]]  <= cyc;
          q_port[slot[p]] <= 2'(p);
          q_addr[slot[p]] <= wr_addr[p*ADDR_W +: ADDR_W];
          q_data[slot[p]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign log_valid = (count != '0);
  assign log_count = count;
  assign log_cycle = log_valid ? q_cyc[rd_ptr]  : '0;
  assign log_port  = log_valid ? q_port[rd_ptr] : '0;
  assign log_addr  = log_valid ? q_addr[rd_ptr] : '0;
  assign log_data  = log_valid ? q_data[rd_ptr] : '0;

endmodule

// File: tb/tb_reg_write_tracer.sv
// Directed bench for reg_write_tracer: vector table for single-cycle writes,
// hand sequences for overflow, clear and mid-drain reset.
module tb_reg_write_tracer;
  localparam int DW = 32, AW = 5, NP = 2, LD = 16, CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NP-1:0]    wr_en;
  logic [NP*AW-1:0] wr_addr;
  logic [NP*DW-1:0] wr_data;
  logic             changes_only, clr_log, log_ready;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             log_valid;
  logic [CW-1:0]    log_cycle;
  logic [1:0]       log_port;
  logic [AW-1:0]    log_addr;
  logic [DW-1:0]    log_data;
  logic [$clog2(LD):0] log_count;
  logic             overflow;
  logic [15:0]      drop_count;

  reg_write_tracer #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP), .LOG_DEPTH(LD), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .changes_only(changes_only), .clr_log(clr_log), .rd_addr(rd_addr), .rd_data(rd_data),
    .log_valid(log_valid), .log_ready(log_ready), .log_cycle(log_cycle), .log_port(log_port),
    .log_addr(log_addr), .log_data(log_data), .log_count(log_count), .overflow(overflow),
    .drop_count(drop_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ecount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;  logic [31:0] d0;
    logic [4:0]  a1;  logic [31:0] d1;
    logic        chg;
    int          exp_n;
    logic [1:0]  p0;  logic [4:0] ea0; logic [31:0] ed0;
    logic [1:0]  p1;  logic [4:0] ea1; logic [31:0] ed1;
    logic [4:0]  rd_a; logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] expq[$];
  int          stampq[$];
  int          stamp;

  initial begin
    vecs[0]  = '{2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 2, 2'd0, 5'd3, 32'hDEADBEEF, 2'd0, 5'd0, 32'h0, 5'd3, 32'hDEADBEEF};
    vecs[0].exp_n = 1;
    vecs[1]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 2, 2'd0, 5'd7, 32'h11, 2'd1, 5'd7, 32'h22, 5'd7, 32'h22};
    vecs[2]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b0, 0, 2'd0, 5'd0, 32'h0, 2'd0, 5'd0, 32'h0, 5'd0, 32'h0};
    vecs[3]  = '{2'b01, 5'd4, 32'h5, 5'd0, 32'h0, 1'b1, 1, 2'd0, 5'd4, 32'h5, 2'd0, 5'd0, 32'h0, 5'd4, 32'h5};
    vecs[4]  = '{2'b01, 5'd4, 32'h5, 5'd0, 32'h0, 1'b1, 0, 2'd0, 5'd0, 32'h0, 2'd0, 5'd0, 32'h0, 5'd4, 32'h5};
    vecs[5]  = '{2'b01, 5'd4, 32'h6, 5'd0, 32'h0, 1'b1, 1, 2'd0, 5'd4, 32'h6, 2'd0, 5'd0, 32'h0, 5'd4, 32'h6};
    vecs[6]  = '{2'b11, 5'd4, 32'h6, 5'd9, 32'h0, 1'b1, 0, 2'd0, 5'd0, 32'h0, 2'd0, 5'd0, 32'h0, 5'd9, 32'h0};
    vecs[7]  = '{2'b11, 5'd4, 32'h6, 5'd9, 32'h0, 1'b0, 2, 2'd0, 5'd4, 32'h6, 2'd1, 5'd9, 32'h0, 5'd4, 32'h6};
    vecs[8]  = '{2'b10, 5'd0, 32'h0, 5'd7, 32'h22, 1'b1, 0, 2'd0, 5'd0, 32'h0, 2'd0, 5'd0, 32'h0, 5'd7, 32'h22};
    vecs[9]  = '{2'b10, 5'd0, 32'h0, 5'd7, 32'h23, 1'b1, 1, 2'd1, 5'd7, 32'h23, 2'd0, 5'd0, 32'h0, 5'd7, 32'h23};
    vecs[10] = '{2'b11, 5'd5, 32'h1, 5'd5, 32'h1, 1'b1, 2, 2'd0, 5'd5, 32'h1, 2'd1, 5'd5, 32'h1, 5'd5, 32'h1};
    vecs[11] = '{2'b00, 5'd8, 32'h9, 5'd8, 32'h9, 1'b0, 0, 2'd0, 5'd0, 32'h0, 2'd0, 5'd0, 32'h0, 5'd8, 32'h0};

    reset = 1'b1; changes_only = 1'b0; clr_log = 1'b0; log_ready = 1'b0; rd_addr = '0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    ecount = 0;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_log_count", log_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_log_cycle", log_cycle, 0);
    chk("rst_log_data", log_data, 0);
    repeat (5) tick();

    // Table of single-cycle write patterns, each fully drained before the next.
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].en, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
      changes_only = vecs[i].chg;
      stamp = ecount;
      tick();
      wr_en = '0;
      rd_addr = vecs[i].rd_a;
      log_ready = (vecs[i].exp_n > 0);
      chk($sformatf("v%0d_count", i), log_count, 64'(vecs[i].exp_n));
      if (vecs[i].exp_n >= 1) begin
        chk($sformatf("v%0d_e0_cycle", i), log_cycle, 64'(stamp));
        chk($sformatf("v%0d_e0_port", i), log_port, vecs[i].p0);
        chk($sformatf("v%0d_e0_addr", i), log_addr, vecs[i].ea0);
        chk($sformatf("v%0d_e0_data", i), log_data, vecs[i].ed0);
      end
      tick();
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      if (vecs[i].exp_n == 2) begin
        chk($sformatf("v%0d_e1_cycle", i), log_cycle, 64'(stamp));
        chk($sformatf("v%0d_e1_port", i), log_port, vecs[i].p1);
        chk($sformatf("v%0d_e1_addr", i), log_addr, vecs[i].ea1);
        chk($sformatf("v%0d_e1_data", i), log_data, vecs[i].ed1);
        tick();
      end
      log_ready = 1'b0;
      chk($sformatf("v%0d_empty", i), log_count, 0);
    end
    changes_only = 1'b0;

    // Overflow: 18 writes into a 16-deep log with the consumer stalled.
    for (int i = 0; i < 18; i++) begin
      wr(2'b01, 5'd10, 32'(100 + i), 5'd0, 32'h0);
      if (expq.size() < LD) begin
        expq.push_back(32'(100 + i));
        stampq.push_back(ecount);
      end
      tick();
    end
    wr_en = '0;
    chk("ovf_count", log_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    chk("ovf_stall_head", log_data, 100);

    // Push and pop together while full: the pop makes room for the push.
    log_ready = 1'b1;
    wr(2'b01, 5'd10, 32'd999, 5'd0, 32'h0);
    void'(expq.pop_front());
    void'(stampq.pop_front());
    expq.push_back(32'd999);
    stampq.push_back(ecount);
    tick();
    wr_en = '0;
    chk("full_pushpop_count", log_count, 16);
    chk("full_pushpop_drops", drop_count, 2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), log_valid, 1);
      chk($sformatf("drain%0d_data", i), log_data, expq[0]);
      chk($sformatf("drain%0d_cycle", i), log_cycle, 64'(stampq[0]));
      void'(expq.pop_front());
      void'(stampq.pop_front());
      tick();
    end
    log_ready = 1'b0;
    chk("drain_done_valid", log_valid, 0);
    chk("drain_done_data", log_data, 0);

    // Two loggable writes with one free slot: port0 kept, port1 dropped.
    for (int i = 0; i < 15; i++) begin
      wr(2'b01, 5'd11, 32'(200 + i), 5'd0, 32'h0);
      tick();
    end
    wr(2'b11, 5'd12, 32'hA, 5'd13, 32'hB);
    tick();
    wr_en = '0;
    chk("mp_drop_count", log_count, 16);
    chk("mp_drop_drops", drop_count, 3);
    chk("mp_drop_head", log_data, 200);

    // Clear the log with a write in the same cycle.
    clr_log = 1'b1;
    wr(2'b01, 5'd14, 32'hC, 5'd0, 32'h0);
    tick();
    clr_log = 1'b0;
    wr_en = '0;
    chk("clr_count", log_count, 0);
    chk("clr_valid", log_valid, 0);
    chk("clr_drops", drop_count, 3);
    chk("clr_overflow", overflow, 1);
    rd_addr = 5'd14; tick();
    chk("clr_shadow14", rd_data, 32'hC);
    rd_addr = 5'd11; tick();
    chk("clr_shadow11", rd_data, 214);
    rd_addr = 5'd13; tick();
    chk("dropped_write_shadow13", rd_data, 32'hB);

    // Reset in the middle of draining.
    for (int i = 0; i < 4; i++) begin
      wr(2'b01, 5'd15, 32'(300 + i), 5'd0, 32'h0);
      tick();
    end
    wr_en = '0;
    log_ready = 1'b1;
    tick();
    chk("pre_rst_count", log_count, 3);
    chk("pre_rst_head", log_data, 301);
    reset = 1'b1;
    wr(2'b01, 5'd16, 32'h55, 5'd0, 32'h0);
    tick();
    reset = 1'b0;
    log_ready = 1'b0;
    ecount = 0;
    chk("mid_rst_valid", log_valid, 0);
    chk("mid_rst_count", log_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drops", drop_count, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_log_addr", log_addr, 0);
    rd_addr = 5'd15;
    wr(2'b10, 5'd0, 32'h0, 5'd16, 32'h77);
    tick();
    wr_en = '0;
    chk("post_rst_cycle", log_cycle, 0);
    chk("post_rst_port", log_port, 1);
    chk("post_rst_addr", log_addr, 16);
    chk("post_rst_shadow15", rd_data, 0);
    rd_addr = 5'd16; tick();
    chk("post_rst_shadow16", rd_data, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
